// File: rtl/bit_position_scanner.sv
// Serialises a WIDTH-bit vector into the positions of its set bits, one per output beat,
// in ascending (LSB-first) or descending (MSB-first) order chosen per vector.
module bit_position_scanner #(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] pos,
    output logic             last,
    output logic             none,
    output logic [POS_W:0]   ones_cnt,
    output logic             o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a producer holds its data until the transfer.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_vec;
    logic               r_mode;
    logic [POS_W:0]     r_ones_cnt;

    logic               w_scan;
    logic [POS_W-1:0]   w_lo_pos;
    logic [POS_W-1:0]   w_hi_pos;
    logic [POS_W-1:0]   w_pos;
    logic               w_last;
    logic               w_none;

    function automatic logic [POS_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [POS_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (POS_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Later assignments win: descending loop finds the lowest bit, ascending the highest.
    always_comb begin
        w_lo_pos = '0;
        w_hi_pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_vec[i]) w_lo_pos = POS_W'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (r_vec[i]) w_hi_pos = POS_W'(i);
        end
    end

    assign w_scan = (r_state == SCAN);
    assign w_pos  = r_mode ? w_hi_pos : w_lo_pos;
    assign w_last = ((r_vec & (r_vec - WIDTH'(1))) == '0);
    assign w_none = (r_vec == '0);

    assign in_ready    = ~w_scan;
    assign out_valid   = w_scan;
    assign pos         = w_scan ? w_pos : '0;
    assign last        = w_scan & w_last;
    assign none        = w_scan & w_none;
    assign ones_cnt    = r_ones_cnt;
    assign o_dbg_state = w_scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_mode     <= 1'b0;
            r_ones_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_vec      <= data_in;
                        r_mode     <= msb_first;
                        r_ones_cnt <= popcount(data_in);
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    // A zero vector clears bit 0, which is already clear.
                    if (out_ready) begin
                        r_vec[w_pos] <= 1'b0;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_position_scanner.md
Name: bit_position_scanner

Overview:
- Parametrised, sequential successor to the team's 8-to-3 first-one encoder.
- Accepts a WIDTH-bit vector over a valid/ready handshake and emits the position of every set bit, one per output beat.
- Scan order is selectable per vector: LSB-first or MSB-first.
- Used wherever a request or flag vector must be serialised into indices, for example interrupt, request or mask walking.

Parameters:
- WIDTH, 8: input vector width, >= 2.
- POS_W, $clog2(WIDTH): width of the position output, derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in and msb_first are valid.
- in_ready  output  1  block can accept a new vector.
- data_in  input  WIDTH  vector to scan.
- msb_first  input  1  0 = emit ascending positions, 1 = emit descending; sampled with data_in.
- out_valid  output  1  pos, last and none are valid.
- out_ready  input  1  consumer accepts the current beat.
- pos  output  POS_W  position of the current set bit.
- last  output  1  current beat is the final beat for this vector.
- none  output  1  accepted vector was all-zero; pos = 0 on this beat.
- ones_cnt  output  POS_W+1  number of set bits in the accepted vector; held for the whole scan.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - Internal vector, mode and ones_cnt are cleared to 0.
  - out_valid = 0, pos = 0, last = 0, none = 0, in_ready = 1.
  - Release is synchronous to the next clk edge.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, register data_in into vec, msb_first into mode, and popcount(data_in) into ones_cnt.
  - Then go to SCAN.
- SCAN:
  - in_ready = 0, out_valid = 1.
  - Mode 0: pos = index of the lowest set bit of vec.
  - Mode 1: pos = index of the highest set bit of vec.
  - last = 1 when vec has at most one set bit.
  - none = 1 when vec == 0. This occurs only when the accepted vector was zero; pos = 0 and last = 1 in that case.
  - On out_valid & out_ready: clear bit pos in vec. If last, go to IDLE; otherwise stay in SCAN.
  - While out_ready = 0: pos, last, none and ones_cnt hold stable; no bit is cleared.
- Latency:
  - Vector accepted at edge N; first beat valid after edge N.
  - Consecutive beats issue every cycle while out_ready = 1.
  - A vector with k set bits (k >= 1) takes k output beats; a zero vector takes 1 beat.
  - After the last handshake the block returns to IDLE for one cycle, so the next vector is accepted one cycle later. No back-to-back acceptance.
- Timing: pos, last and none are decoded from registered state only. There is no combinational path from in_* or out_ready to out_valid, pos, last or none.
- Boundary conditions:
  - All-ones vector: WIDTH beats; ones_cnt = WIDTH (needs the extra bit).
  - Bit 0 only, or bit WIDTH-1 only: single beat with last = 1, in either mode.
  - in_valid asserted during SCAN is ignored; the producer must hold it until in_ready.
  - Changes on data_in or msb_first during SCAN have no effect.
  - rst_n asserted mid-scan drops out_valid immediately (asynchronously). The remaining positions are discarded.

Test Plan:
- WIDTH=8, mode 0, data_in = 8'd12, out_ready held 1:
  - first beat one cycle after acceptance, pos = 2, last = 0;
  - then pos = 3, last = 1;
  - ones_cnt = 2; in_ready returns to 1 the cycle after.
- WIDTH=8, mode 1, data_in = 8'd125:
  - pos sequence 6, 5, 4, 3, 2, 0 on consecutive cycles, last only on pos = 0;
  - ones_cnt = 6.
- data_in = 8'd0, any mode: single beat with none = 1, pos = 0, last = 1, ones_cnt = 0; then IDLE.
- data_in = 8'd100 in mode 0, out_ready low for 3 cycles after the first beat:
  - pos = 2 stays held for those 3 cycles, with no bit loss;
  - then 5, 6 (last);
  - in_valid with a new vector during the scan is not accepted until in_ready = 1.
- data_in = 8'd255 in mode 0, rst_n pulsed low after the 3rd beat:
  - out_valid, pos and last go to 0 without waiting for clk; in_ready = 1;
  - a following vector 8'd9 in mode 1 yields 3, 0.
- WIDTH=16, data_in = 16'h8001:
  - mode 0 yields 0, 15;
  - mode 1 yields 15, 0;
  - POS_W = 4 and ones_cnt = 2.
